// File: rtl/mcparc_host_monitor_if.sv
// Signal bundle between the end-of-test monitor and whatever drives it
// (simulation harness or FPGA host).
//   slave  : the monitor side. It takes the limit, stats enable, status words and
//            retire pulses, and drives the verdict, done and statistics.
//   master : the harness side, which is the mirror image of slave.
interface mcparc_host_monitor_if #(
  parameter int p_num_cores = 1,
  parameter int p_status_sz = 32,
  parameter int p_cnt_sz    = 32
) ();
  localparam int p_fc_sz = (p_num_cores > 1) ? $clog2(p_num_cores) : 1;

  logic [p_cnt_sz-1:0]                max_cycles;
  logic                               stats_en;
  logic [p_num_cores*p_status_sz-1:0] status;
  logic [p_num_cores-1:0]             inst_retire;

  logic                               pass;
  logic                               fail;
  logic                               timeout;
  logic [p_fc_sz-1:0]                 fail_core;
  logic [p_status_sz-1:0]             fail_status;
  logic                               done;
  logic [p_cnt_sz-1:0]                num_cycles;
  logic [p_cnt_sz-1:0]                num_inst;

  modport master (
    output max_cycles, stats_en, status, inst_retire,
    input  pass, fail, timeout, fail_core, fail_status, done, num_cycles, num_inst
  );

  modport slave (
    input  max_cycles, stats_en, status, inst_retire,
    output pass, fail, timeout, fail_core, fail_status, done, num_cycles, num_inst
  );
endinterface

// File: rtl/mcparc_host_monitor.sv
// End-of-test monitor for a multi-core processor harness. It has three states:
// RUN, then DRAIN, then DONE.
// In RUN it does three things:
//   - It latches the first nonzero CP0 status word of each core.
//   - It counts cycles and retired instructions.
//   - It resolves one pass/fail/timeout verdict, with priority fail > pass > timeout.
// After the verdict it drains for p_drain_cycles and then raises done.
// Ports:
//   clk, reset : clock and synchronous active-high reset.
//   mon        : mcparc_host_monitor_if.slave. It carries the limit, stats
//                enable, status and retire inputs, and the verdict, done and
//                statistics outputs.

// One core's finished flag and latched status. lat_n and fin_n are the values
// after this cycle's capture is merged in, so the verdict can use them in
// the same cycle.
module mcparc_core_latch #(
  parameter int p_status_sz = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [p_status_sz-1:0] status,
  output logic                   fin_n,
  output logic [p_status_sz-1:0] lat_n
);
  logic                   fin_q;
  logic [p_status_sz-1:0] lat_q;
  logic                   cap;

  // Only the first nonzero status is captured. Later changes are ignored until reset.
  assign cap   = en && !fin_q && (status != '0);
  assign fin_n = fin_q | cap;
  assign lat_n = cap ? status : lat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fin_q <= 1'b0;
      lat_q <= '0;
    end else begin
      fin_q <= fin_n;
      lat_q <= lat_n;
    end
  end
endmodule

module mcparc_host_monitor #(
  parameter int p_num_cores    = 1,
  parameter int p_status_sz    = 32,
  parameter int p_cnt_sz       = 32,
  parameter int p_drain_cycles = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mcparc_host_monitor_if.slave  mon
);
  localparam int FC_W = (p_num_cores > 1) ? $clog2(p_num_cores) : 1;
  localparam int DW   = (p_drain_cycles > 1) ? $clog2(p_drain_cycles) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                                  state_q, state_d;
  logic                                    run;
  logic [p_num_cores-1:0]                  fin_n;
  logic [p_num_cores-1:0][p_status_sz-1:0] lat_n;

  logic [p_cnt_sz-1:0]    cycle_cnt, num_cycles_q, num_inst_q, retire_cnt;
  logic [p_cnt_sz:0]      cyc_inc;
  logic [DW-1:0]          drain_q;
  logic                   pass_q, fail_q, timeout_q, done_q;
  logic [FC_W-1:0]        fail_core_q, fail_idx;
  logic [p_status_sz-1:0] fail_status_q, fail_val;
  logic                   fail_any, all_one, pass_all, tmo, verdict;

  assign run = (state_q == S_RUN);

  for (genvar g = 0; g < p_num_cores; g++) begin : g_core
    mcparc_core_latch #(.p_status_sz(p_status_sz)) u_latch (
      .clk    (clk),
      .reset  (reset),
      .en     (run),
      .status (mon.status[g*p_status_sz +: p_status_sz]),
      .fin_n  (fin_n[g]),
      .lat_n  (lat_n[g])
    );
  end

  // Verdict terms use the latched values merged with this cycle's captures.
  // The scan runs from high to low, so the lowest failing index wins.
  always_comb begin
    fail_any   = 1'b0;
    fail_idx   = '0;
    fail_val   = '0;
    all_one    = 1'b1;
    retire_cnt = '0;
    for (int i = p_num_cores - 1; i >= 0; i--) begin
      if (fin_n[i] && (lat_n[i] > p_status_sz'(1))) begin
        fail_any = 1'b1;
        fail_idx = FC_W'(i);
        fail_val = lat_n[i];
      end
      if (lat_n[i] != p_status_sz'(1)) all_one = 1'b0;
      retire_cnt = retire_cnt + p_cnt_sz'(mon.inst_retire[i]);
    end
  end

  // The compare is one bit wider, so a saturated cycle_cnt cannot wrap past the limit.
  assign cyc_inc  = (p_cnt_sz+1)'(cycle_cnt) + (p_cnt_sz+1)'(1);
  assign tmo      = (mon.max_cycles != '0) && (cyc_inc >= {1'b0, mon.max_cycles});
  assign pass_all = (&fin_n) && all_one;
  assign verdict  = fail_any || pass_all || tmo;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (verdict) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt     <= '0;
      num_cycles_q  <= '0;
      num_inst_q    <= '0;
      drain_q       <= '0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      fail_core_q   <= '0;
      fail_status_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (mon.stats_en) begin
            num_cycles_q <= num_cycles_q + 1'b1;
            num_inst_q   <= num_inst_q + retire_cnt;
          end
          if (fail_any) begin
            fail_q        <= 1'b1;
            fail_core_q   <= fail_idx;
            fail_status_q <= fail_val;
          end else if (pass_all) begin
            pass_q <= 1'b1;
          end else if (tmo) begin
            timeout_q <= 1'b1;
          end
          drain_q <= DW'(p_drain_cycles - 1);
        end
        S_DRAIN: begin
          if (drain_q != '0) drain_q <= drain_q - 1'b1;
          else               done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mon.pass        = pass_q;
  assign mon.fail        = fail_q;
  assign mon.timeout     = timeout_q;
  assign mon.fail_core   = fail_core_q;
  assign mon.fail_status = fail_status_q;
  assign mon.done        = done_q;
  assign mon.num_cycles  = num_cycles_q;
  assign mon.num_inst    = num_inst_q;
endmodule

// File: tb/tb_mcparc_host_monitor.sv
// Scoreboard bench for mcparc_host_monitor.
// Each scenario is described by three things:
//   - the cycle at which each core first reports a nonzero status, and that value;
//   - the timeout limit;
//   - per-cycle stats_en and retire vectors.
// The model derives the verdict from these with min/max arithmetic.
// The monitor process checks the DUT whenever a verdict or done appears.
module tb_mcparc_host_monitor;
  localparam int NC   = 4;
  localparam int SW   = 8;
  localparam int CW   = 16;
  localparam int D    = 2;
  localparam int MAXL = 140;
  localparam int BIG  = 1 << 30;

  typedef struct {
    logic [2:0] vbits;   // {pass, fail, timeout}
    int         fc;
    int         fs;
    int         nc;
    int         ni;
    int         kv;
    bit         no_done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcparc_host_monitor_if #(.p_num_cores(NC), .p_status_sz(SW), .p_cnt_sz(CW)) bus ();

  mcparc_host_monitor #(
    .p_num_cores(NC), .p_status_sz(SW), .p_cnt_sz(CW), .p_drain_cycles(D)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .mon   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  // Scenario description
  int          t_a   [NC];
  logic [SW-1:0] v_a [NC];
  bit          noise [NC];
  int          m_lim;
  bit          sen_a [MAXL+1];
  logic [NC-1:0] ret_a [MAXL+1];

  int ecnt = 0;
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int kf, kp, kt, kv;
    bit all_pass;
    kf = BIG;
    all_pass = 1'b1;
    kp = 0;
    for (int i = 0; i < NC; i++) begin
      if (t_a[i] != 0 && v_a[i] > 1 && t_a[i] < kf) kf = t_a[i];
      if (t_a[i] == 0 || v_a[i] != 1) all_pass = 1'b0;
      else if (t_a[i] > kp) kp = t_a[i];
    end
    if (!all_pass) kp = BIG;
    kt = (m_lim != 0) ? m_lim : BIG;
    e.fc = 0; e.fs = 0; e.no_done = 1'b0;
    if (kf <= kp && kf <= kt && kf != BIG) begin
      kv = kf;
      e.vbits = 3'b010;
      for (int i = NC - 1; i >= 0; i--)
        if (t_a[i] != 0 && t_a[i] <= kf && v_a[i] > 1) begin
          e.fc = i; e.fs = int'(v_a[i]);
        end
    end else if (kp <= kt && kp != BIG) begin
      kv = kp;
      e.vbits = 3'b100;
    end else begin
      kv = kt;
      e.vbits = 3'b001;
    end
    e.kv = kv;
    e.nc = 0; e.ni = 0;
    if (kv != BIG)
      for (int k = 1; k <= kv; k++)
        if (sen_a[k]) begin
          e.nc++;
          e.ni += $countones(ret_a[k]);
        end
    return e;
  endfunction

  task automatic clr_scn();
    m_lim = 0;
    for (int i = 0; i < NC; i++) begin
      t_a[i] = 0; v_a[i] = 8'd1; noise[i] = 1'b1;
    end
    for (int k = 0; k <= MAXL; k++) begin
      sen_a[k] = 1'b1; ret_a[k] = '0;
    end
  endtask

  task automatic rand_scn();
    m_lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 120));
    for (int i = 0; i < NC; i++) begin
      t_a[i]   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 100));
      v_a[i]   = ($urandom_range(0, 9) < 7) ? 8'd1 : SW'($urandom_range(2, 255));
      noise[i] = 1'($urandom);
    end
    for (int k = 0; k <= MAXL; k++) begin
      sen_a[k] = ($urandom_range(0, 3) != 0);
      ret_a[k] = NC'($urandom);
    end
  endtask

  task automatic apply(input int k);
    logic [SW-1:0] s;
    bus.stats_en    = sen_a[k];
    bus.inst_retire = ret_a[k];
    for (int i = 0; i < NC; i++) begin
      if (t_a[i] == 0 || k < t_a[i]) s = '0;
      else if (k == t_a[i])          s = v_a[i];
      else                           s = noise[i] ? SW'($urandom) : v_a[i];
      bus.status[i*SW +: SW] = s;
    end
  endtask

  task automatic idle_inputs();
    bus.stats_en    = 1'b0;
    bus.inst_retire = '0;
    bus.status      = '0;
  endtask

  function automatic longint out_vec();
    return longint'({bus.pass, bus.fail, bus.timeout, bus.done, bus.fail_core,
                     bus.fail_status, bus.num_cycles, bus.num_inst});
  endfunction

  // Runs one scenario from reset. With rst_in_drain, reset is pulsed on the
  // first DRAIN edge and done must then never appear.
  task automatic run_scn(input bit rst_in_drain);
    exp_t e;
    e = model();
    if (e.kv == BIG) begin
      m_lim = int'($urandom_range(1, 120));
      e = model();
    end
    e.no_done = rst_in_drain;
    idle_inputs();
    bus.max_cycles = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", out_vec(), 0);
    sb.push_back(e);
    bus.max_cycles = CW'(m_lim);
    rst = 1'b0;
    for (int k = 1; k <= e.kv + D + 3; k++) begin
      apply(k);
      if (rst_in_drain && k == e.kv + 1) rst = 1'b1;
      @(posedge clk);
      #1;
      if (rst_in_drain && k == e.kv + 1) begin
        chk("drain_reset_state", out_vec(), 0);
        bus.max_cycles = '0;
        idle_inputs();
        rst = 1'b0;
        repeat (D + 3) @(posedge clk);
        #1;
        chk("done_after_drain_reset", bus.done, 0);
        break;
      end
    end
    if (!rst_in_drain) chk("done_reached", bus.done, 1);
  endtask

  // Monitor: compares against the scoreboard whenever a verdict or done rises.
  initial begin
    logic [2:0] cur_v, prev_v;
    logic       prev_done;
    int         exp_done, exp_nc;
    exp_t       it;
    prev_v = '0; prev_done = 1'b0; exp_done = -1; exp_nc = 0;
    forever begin
      @(negedge clk);
      cur_v = {bus.pass, bus.fail, bus.timeout};
      if (cur_v != 3'b000 && prev_v == 3'b000) begin
        if (sb.size() == 0) begin
          chk("spurious_verdict", longint'(cur_v), 0);
        end else begin
          it = sb.pop_front();
          chk("verdict_bits", longint'(cur_v), longint'(it.vbits));
          chk("verdict_edge", ecnt, it.kv);
          chk("fail_core", bus.fail_core, it.fc);
          chk("fail_status", bus.fail_status, it.fs);
          chk("num_cycles", bus.num_cycles, it.nc);
          chk("num_inst", bus.num_inst, it.ni);
          exp_done = it.no_done ? -1 : it.kv + D;
          exp_nc   = it.nc;
        end
      end
      if (bus.done && !prev_done) begin
        if (exp_done < 0) chk("unexpected_done", 1, 0);
        else begin
          chk("done_edge", ecnt, exp_done);
          chk("num_cycles_frozen", bus.num_cycles, exp_nc);
        end
        exp_done = -1;
      end
      prev_v    = cur_v;
      prev_done = bus.done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected end", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.max_cycles = '0;

    // 1: pass after cycle 20, 10 single-core retires.
    clr_scn();
    for (int i = 0; i < NC; i++) t_a[i] = 20;
    for (int k = 1; k <= 10; k++) ret_a[k] = 4'b0001;
    run_scn(1'b0);
    chk("t1_pass", bus.pass, 1);
    chk("t1_ninst", bus.num_inst, 10);
    chk("t1_ncyc", bus.num_cycles, 20);

    // 2: core 0 passes, then cores 3 and 2 fail on the same cycle.
    clr_scn();
    t_a[0] = 3;  v_a[0] = 8'd1;
    t_a[2] = 10; v_a[2] = 8'd7;
    t_a[3] = 10; v_a[3] = 8'd5;
    run_scn(1'b0);
    chk("t2_fail", bus.fail, 1);
    chk("t2_core", bus.fail_core, 2);
    chk("t2_stat", bus.fail_status, 7);
    chk("t2_pass", bus.pass, 0);

    // 3: timeout at 50 with no status.
    clr_scn();
    m_lim = 50;
    run_scn(1'b0);
    chk("t3_timeout", bus.timeout, 1);
    chk("t3_ncyc", bus.num_cycles, 50);

    // 4: pass on the same edge as the timeout condition.
    clr_scn();
    m_lim = 30;
    for (int i = 0; i < NC; i++) t_a[i] = 30;
    run_scn(1'b0);
    chk("t4_pass", bus.pass, 1);
    chk("t4_timeout", bus.timeout, 0);

    // 5: reset during DRAIN, then a normal rerun.
    clr_scn();
    for (int i = 0; i < NC; i++) t_a[i] = 8;
    run_scn(1'b1);
    run_scn(1'b0);
    chk("t5_rerun_pass", bus.pass, 1);

    // 6: stats disabled throughout.
    clr_scn();
    for (int k = 0; k <= MAXL; k++) begin
      sen_a[k] = 1'b0; ret_a[k] = NC'($urandom);
    end
    for (int i = 0; i < NC; i++) t_a[i] = 25;
    run_scn(1'b0);
    chk("t6_ncyc", bus.num_cycles, 0);
    chk("t6_ninst", bus.num_inst, 0);
    chk("t6_pass", bus.pass, 1);

    // 7: status 1 and status 5 on the same edge give fail.
    clr_scn();
    for (int i = 0; i < NC; i++) t_a[i] = 15;
    v_a[1] = 8'd5;
    run_scn(1'b0);
    chk("t7_fail", bus.fail, 1);
    chk("t7_core", bus.fail_core, 1);

    // Random scenarios.
    for (int n = 0; n < 40; n++) begin
      rand_scn();
      run_scn(1'b0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mcparc_host_monitor.md
# mcparc_host_monitor

Synthesisable, parametrised replacement for the behavioural end-of-test logic in the processor simulation harness. It watches the CP0 status word of `p_num_cores` processors, accumulates cycle and retired-instruction statistics, and enforces a run-time cycle limit. It resolves a single registered pass/fail/timeout verdict and asserts `done` after a programmable drain period. The harness (or an FPGA host) calls `$finish` or stops clocking on `done`.

## Interface
- `p_num_cores`, default 1: number of monitored cores (1–16).
- `p_status_sz`, default 32: width of each status word.
- `p_cnt_sz`, default 32: width of the cycle, instruction and limit counters.
- `p_drain_cycles`, default 2: cycles spent in DRAIN before `done` (≥1).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `max_cycles` input `p_cnt_sz`: timeout limit; 0 disables timeout.
- `stats_en` input 1: enables the statistic counters.
- `status` input `p_num_cores*p_status_sz`: core i occupies bits `[i*p_status_sz +: p_status_sz]`.
- `inst_retire` input `p_num_cores`: per-core one-cycle retire pulse.
- `pass` output 1: all cores reported status 1.
- `fail` output 1: some core reported status > 1.
- `timeout` output 1: limit reached before a verdict.
- `fail_core` output `$clog2(p_num_cores)` (min 1): index of the failing core.
- `fail_status` output `p_status_sz`: latched status of `fail_core`.
- `done` output 1: verdict final, drain complete.
- `num_cycles` output `p_cnt_sz`: stats-enabled cycles counted in RUN.
- `num_inst` output `p_cnt_sz`: retired instructions counted in RUN.

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN.
- Reset clears all outputs, counters, per-core finished flags and latched statuses to 0.
- RUN:
  - `cycle_cnt` (internal) increments every cycle and saturates at all-ones.
  - If `stats_en` is set, `num_cycles` increments by 1.
  - If `stats_en` is set, `num_inst` increments by the popcount of `inst_retire`.
  - Both statistic counters wrap modulo 2^`p_cnt_sz`.
- Per-core latch: when core i's status is nonzero and its finished flag is clear, set the flag and capture the status. Later status changes on that core are ignored until reset.
- Verdict is evaluated each RUN cycle on the latched values merged with this cycle's captures. Priority is fail > pass > timeout:
  - fail: any latched status > 1. `fail_core` is the lowest such index; `fail_status` is its value. Does not wait for the other cores.
  - pass: every core is finished and every latched status == 1.
  - timeout: `max_cycles != 0` and `cycle_cnt + 1 >= max_cycles`.
- On a verdict, set exactly one of `pass`, `fail`, `timeout` and go to DRAIN. Verdict outputs hold until reset.
- DRAIN: a counter loads `p_drain_cycles-1` and decrements each cycle. On reaching 0, go to DONE. Statistic counters and status latches are frozen.
- DONE: `done` = 1. Terminal until reset.
- `reset` asserted in any state returns the block to RUN with everything cleared on the next edge, including mid-DRAIN.
- Status inputs are ignored outside RUN.

## Timing
- A status first nonzero before edge k gives the verdict output high after edge k (1-cycle latency).
- `done` rises exactly `p_drain_cycles` edges after the verdict edge.
- `num_cycles` counts RUN cycles including the verdict cycle, excluding DRAIN and DONE.
- With `max_cycles = M`, timeout is asserted after the M-th RUN edge following reset deassertion.
- A pass or fail on the same edge as the timeout condition wins; `timeout` stays 0.
- A core at status 1 while another core's status goes to 5 on the same edge gives fail, not pass.
- No handshakes; all inputs are sampled every cycle.

## Test plan
- 1 core, `stats_en = 1`, retire on 10 cycles, status = 1 at cycle 20 -> `pass` after edge 20, `done` 2 cycles later, `num_inst = 10`, `num_cycles = 20`.
- 4 cores, core 0 at status 1, then cores 3 and 2 at status 5 and 7 on the same cycle -> `fail`, `fail_core = 2`, `fail_status = 7`, `pass = 0`.
- `max_cycles = 50`, status held at 0 -> `timeout` after 50 RUN edges, `num_cycles` frozen at 50 through DONE.
- `max_cycles = 30`, status = 1 on cycle 30 -> `pass = 1`, `timeout = 0`.
- Verdict reached, then `reset` pulsed during DRAIN -> all outputs 0 and `done` never asserted. Rerun after reset gives a normal pass.
- `stats_en = 0` throughout with retire pulses -> `num_cycles = num_inst = 0`; the verdict still occurs.
